// File: rtl/pipe_stage_skid.sv
// Purpose     : valid/ready pipeline stage register with flush and optional one-entry skid buffer.
// Latency     : 1 cycle from accept to out_data; no combinational in->out path.
// Backpressure: SKID=1 -> in_ready registered (low only while skid is full); SKID=0 -> in_ready = !out_valid | out_ready.
//
// Ports:
//   i_clk        clock, all state updates on posedge
//   i_reset      synchronous active-high reset, clears all state
//   i_flush      kills all held entries next cycle (data registers left as-is)
//   i_in_valid   upstream payload present on i_in_data
//   o_in_ready   stage can accept this cycle
//   i_in_data    payload from upstream [WIDTH-1:0]
//   o_out_valid  o_out_data holds a live payload
//   i_out_ready  downstream consumes this cycle
//   o_out_data   payload to downstream [WIDTH-1:0], driven only from the main register
//   o_count      entries held (0..2)
module pipe_stage_skid #(
    parameter int WIDTH = 16,
    parameter int SKID  = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [1:0]       o_count
);

    // Encoding is {main_v, skid_v}; {0,1} cannot be reached.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main_d;
    logic [WIDTH-1:0] r_skid_d;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    // With the skid entry, ready depends only on local state, which breaks
    // the combinational ready chain back through the pipeline.
    assign o_in_ready  = (SKID != 0) ? (r_state != ST_FULL)
                                     : ((r_state == ST_EMPTY) | i_out_ready);
    assign o_out_valid = r_state[1];
    assign o_out_data  = r_main_d;
    assign o_count     = {1'b0, r_state[1]} + {1'b0, r_state[0]};

    assign w_in_fire   = i_in_valid & o_in_ready;
    assign w_out_fire  = r_state[1] & i_out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                // For SKID=0 an accept here always coincides with an issue,
                // so the entry is simply replaced at full rate.
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        // Flush drops everything held, including anything accepted this cycle;
        // an issue in this cycle has already been taken by downstream.
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_main_d <= '0;
            r_skid_d <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_d <= i_in_data;
            end else if (w_load_main_skid) begin
                r_main_d <= r_skid_d;
            end
            if (w_load_skid) begin
                r_skid_d <= i_in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data16;
    logic [36:0] in_data37;

    // index 0: W16/SKID1, 1: W16/SKID0, 2: W37/SKID1, 3: W37/SKID0
    logic        ir  [4];
    logic        ov  [4];
    logic [1:0]  cnt [4];
    logic [15:0] od16 [2];
    logic [36:0] od37 [2];

    int checks;
    int failures;

    pipe_stage_skid #(.WIDTH(16), .SKID(1)) u_a (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(ir[0]), .i_in_data(in_data16), .o_out_valid(ov[0]),
        .i_out_ready(out_ready), .o_out_data(od16[0]), .o_count(cnt[0]));

    pipe_stage_skid #(.WIDTH(16), .SKID(0)) u_b (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(ir[1]), .i_in_data(in_data16), .o_out_valid(ov[1]),
        .i_out_ready(out_ready), .o_out_data(od16[1]), .o_count(cnt[1]));

    pipe_stage_skid #(.WIDTH(37), .SKID(1)) u_c (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(ir[2]), .i_in_data(in_data37), .o_out_valid(ov[2]),
        .i_out_ready(out_ready), .o_out_data(od37[0]), .o_count(cnt[2]));

    pipe_stage_skid #(.WIDTH(37), .SKID(0)) u_d (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(ir[3]), .i_in_data(in_data37), .o_out_valid(ov[3]),
        .i_out_ready(out_ready), .o_out_data(od37[1]), .o_count(cnt[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Leaves the bench just after a negedge, with reset released and no
    // posedge yet seen since release.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data16 = 16'hBEEF; in_data37 = 37'hBEEF;
        repeat (2) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ov[i] !== 1'b0) begin failures++; $display("FAIL reset_out_valid dut%0d got=%b exp=0", i, ov[i]); end
            checks++;
            if (cnt[i] !== 2'd0) begin failures++; $display("FAIL reset_count dut%0d got=%0d exp=0", i, cnt[i]); end
            checks++;
            if (ir[i] !== 1'b1) begin failures++; $display("FAIL reset_in_ready dut%0d got=%b exp=1", i, ir[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (od16[i] !== 16'h0) begin failures++; $display("FAIL reset_out_data16 dut%0d got=%h exp=0", i, od16[i]); end
            checks++;
            if (od37[i] !== 37'h0) begin failures++; $display("FAIL reset_out_data37 dut%0d got=%h exp=0", i + 2, od37[i]); end
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ov[i] !== 1'b0) begin failures++; $display("FAIL reset_no_capture dut%0d got=%b exp=0", i, ov[i]); end
        end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            in_valid  = (k < 8);
            in_data16 = 16'(k + 1);
            out_ready = 1'b1;
            #1;
            for (int d = 0; d < 2; d++) begin
                if (k < 8) begin
                    checks++;
                    if (ir[d] !== 1'b1) begin failures++; $display("FAIL stream_in_ready dut%0d k=%0d got=%b exp=1", d, k, ir[d]); end
                end
                if (k >= 1 && k <= 8) begin
                    checks++;
                    if (ov[d] !== 1'b1 || od16[d] !== 16'(k) || cnt[d] !== 2'd1) begin
                        failures++;
                        $display("FAIL stream_out dut%0d k=%0d got v=%b d=%h c=%0d exp v=1 d=%h c=1",
                                 d, k, ov[d], od16[d], cnt[d], 16'(k));
                    end
                end
                if (k == 9) begin
                    checks++;
                    if (ov[d] !== 1'b0 || cnt[d] !== 2'd0) begin
                        failures++; $display("FAIL stream_drain dut%0d got v=%b c=%0d exp v=0 c=0", d, ov[d], cnt[d]);
                    end
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall_skid();
        logic [15:0] got[$];
        logic [15:0] exp_seq[3];
        logic [15:0] exp_at[4];
        logic        exp_rdy[4];
        logic [1:0]  exp_cnt[4];
        bit          accepted;
        exp_seq = '{16'h00A1, 16'h00A2, 16'h00A3};
        exp_at  = '{16'h0000, 16'h00A1, 16'h00A1, 16'h00A1};
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
        exp_cnt = '{2'd0, 2'd1, 2'd2, 2'd2};
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data16 = (k < 3) ? exp_seq[k] : exp_seq[2];
            #1;
            checks++;
            if (ir[0] !== exp_rdy[k] || cnt[0] !== exp_cnt[k]) begin
                failures++;
                $display("FAIL stall_fill k=%0d got rdy=%b cnt=%0d exp rdy=%b cnt=%0d", k, ir[0], cnt[0], exp_rdy[k], exp_cnt[k]);
            end
            if (k > 0) begin
                checks++;
                if (od16[0] !== exp_at[k]) begin failures++; $display("FAIL stall_hold k=%0d got=%h exp=%h", k, od16[0], exp_at[k]); end
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        accepted  = 1'b0;
        for (int n = 0; n < 12; n++) begin
            #1;
            if (ov[0]) got.push_back(od16[0]);
            if (in_valid && ir[0]) accepted = 1'b1;
            @(negedge clk);
            if (accepted) in_valid = 1'b0;
        end
        checks++;
        if (!accepted) begin failures++; $display("FAIL stall_a3_accept got=0 exp=1 within 12 cycles"); end
        checks++;
        if (got.size() != 3) begin
            failures++; $display("FAIL stall_drain_count got=%0d exp=3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== exp_seq[i]) begin failures++; $display("FAIL stall_order idx=%0d got=%h exp=%h", i, got[i], exp_seq[i]); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data16 = 16'h0011; @(negedge clk);
        in_data16 = 16'h0022; @(negedge clk);
        flush = 1'b1; in_data16 = 16'h0033;
        #1;
        checks++;
        if (cnt[0] !== 2'd2 || ir[0] !== 1'b0) begin
            failures++; $display("FAIL flush_pre got cnt=%0d rdy=%b exp cnt=2 rdy=0", cnt[0], ir[0]);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || cnt[0] !== 2'd0 || ir[0] !== 1'b1) begin
            failures++; $display("FAIL flush_post got v=%b cnt=%0d rdy=%b exp v=0 cnt=0 rdy=1", ov[0], cnt[0], ir[0]);
        end
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            #1;
            checks++;
            if (ov[0] !== 1'b0) begin failures++; $display("FAIL flush_emit n=%0d got v=%b d=%h exp v=0", n, ov[0], od16[0]); end
        end
        // Flush with one entry held: in_ready stays high, the accept is dropped.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data16 = 16'h0055;
        @(negedge clk);
        flush = 1'b1; in_data16 = 16'h0044;
        #1;
        checks++;
        if (ir[0] !== 1'b1) begin failures++; $display("FAIL flush_one_rdy got=%b exp=1", ir[0]); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || cnt[0] !== 2'd0) begin
            failures++; $display("FAIL flush_one_post got v=%b cnt=%0d exp v=0 cnt=0", ov[0], cnt[0]);
        end
    endtask

    task automatic test_skid0_stall();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data16 = 16'h5555;
        #1;
        checks++;
        if (ir[1] !== 1'b1) begin failures++; $display("FAIL s0_empty_rdy got=%b exp=1", ir[1]); end
        @(negedge clk);
        in_data16 = 16'h1234;
        #1;
        checks++;
        if (ir[1] !== 1'b0 || od16[1] !== 16'h5555 || cnt[1] !== 2'd1) begin
            failures++; $display("FAIL s0_full_stall got rdy=%b d=%h cnt=%0d exp rdy=0 d=5555 cnt=1", ir[1], od16[1], cnt[1]);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (ir[1] !== 1'b1 || ov[1] !== 1'b1 || od16[1] !== 16'h5555) begin
            failures++; $display("FAIL s0_release got rdy=%b v=%b d=%h exp rdy=1 v=1 d=5555", ir[1], ov[1], od16[1]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (ov[1] !== 1'b1 || od16[1] !== 16'h1234 || cnt[1] !== 2'd1) begin
            failures++; $display("FAIL s0_replace got v=%b d=%h cnt=%0d exp v=1 d=1234 cnt=1", ov[1], od16[1], cnt[1]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ov[1] !== 1'b0) begin failures++; $display("FAIL s0_drain got v=%b exp=0", ov[1]); end
    endtask

    task automatic test_random();
        logic [36:0] qm[2][$];
        logic [36:0] prev_d[2];
        bit          hold[2];
        logic [63:0] rnd;
        bit          exp_rdy;
        bit          fin;
        bit          fout;
        do_reset();
        hold = '{1'b0, 1'b0};
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 5);
            rnd       = {$urandom, $urandom};
            in_data37 = rnd[36:0];
            in_data16 = rnd[15:0];
            #1;
            for (int m = 0; m < 2; m++) begin
                // m=0: two-entry stage, m=1: single-entry stage
                if (m == 0) exp_rdy = (qm[m].size() < 2);
                else        exp_rdy = (qm[m].size() == 0) || out_ready;
                checks++;
                if (ir[m + 2] !== exp_rdy) begin
                    failures++; $display("FAIL rnd_in_ready dut%0d cyc=%0d got=%b exp=%b", m + 2, cyc, ir[m + 2], exp_rdy);
                end
                checks++;
                if (ov[m + 2] !== (qm[m].size() != 0) || int'(cnt[m + 2]) != qm[m].size()) begin
                    failures++; $display("FAIL rnd_occupancy dut%0d cyc=%0d got v=%b cnt=%0d exp size=%0d",
                                         m + 2, cyc, ov[m + 2], cnt[m + 2], qm[m].size());
                end
                checks++;
                if (cnt[m + 2] > 2'd2 || (m == 1 && cnt[m + 2] > 2'd1)) begin
                    failures++; $display("FAIL rnd_count_bound dut%0d cyc=%0d got=%0d", m + 2, cyc, cnt[m + 2]);
                end
                if (qm[m].size() != 0) begin
                    checks++;
                    if (od37[m] !== qm[m][0]) begin
                        failures++; $display("FAIL rnd_order dut%0d cyc=%0d got=%h exp=%h", m + 2, cyc, od37[m], qm[m][0]);
                    end
                end
                if (hold[m]) begin
                    checks++;
                    if (od37[m] !== prev_d[m]) begin
                        failures++; $display("FAIL rnd_stable dut%0d cyc=%0d got=%h exp=%h", m + 2, cyc, od37[m], prev_d[m]);
                    end
                end
                hold[m]   = (qm[m].size() != 0) && !out_ready && !flush;
                prev_d[m] = od37[m];
                fin  = in_valid && exp_rdy;
                fout = (qm[m].size() != 0) && out_ready;
                if (flush) begin
                    qm[m].delete();
                end else begin
                    if (fout) void'(qm[m].pop_front());
                    if (fin)  qm[m].push_back(in_data37);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data16 = '0; in_data37 = '0;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_skid0_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
